// File: rtl/smart_stack.sv
// Hardware data stack: eight-entry shift-register stack with registered views of the top two
// entries. One operation per clock, selected by a 3-bit code and gated by a store strobe.
module smart_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fetch,
  input  logic             i_store,
  input  logic [2:0]       i_function,
  input  logic [WIDTH-1:0] i_write_D,
  output logic [WIDTH-1:0] o_read_A,
  output logic [WIDTH-1:0] o_read_B
);

  typedef enum logic [2:0] {
    OpNop   = 3'b000,
    OpPush  = 3'b001,
    OpDrop  = 3'b010,
    OpDup   = 3'b011,
    OpSwap  = 3'b100,
    OpOver  = 3'b101,
    OpRepl1 = 3'b110,
    OpRepl2 = 3'b111
  } op_e;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  always_comb begin
    stack_d = stack_q;
    // i_function may be undriven while i_store is low, so decode only under the strobe.
    if (i_store) begin
      case (op_e'(i_function))
        OpPush: begin
          for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
          stack_d[0] = i_write_D;
        end
        OpDrop: begin
          for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          stack_d[DEPTH-1] = '0;
        end
        OpDup: begin
          for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
        end
        OpSwap: begin
          stack_d[0] = stack_q[1];
          stack_d[1] = stack_q[0];
        end
        OpOver: begin
          for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
          stack_d[0] = stack_q[1];
        end
        OpRepl1: stack_d[0] = i_write_D;
        OpRepl2: begin
          // A and B consumed, result pushed: everything below B moves up one slot.
          for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          stack_d[DEPTH-1] = '0;
          stack_d[0]       = i_write_D;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stack_q  <= '{default: '0};
      o_read_A <= '0;
      o_read_B <= '0;
    end else begin
      stack_q <= stack_d;
      // Outputs take the post-operation values of the same edge.
      if (i_fetch) begin
        o_read_A <= stack_d[0];
        o_read_B <= stack_d[1];
      end
    end
  end

endmodule

// File: tb/tb_smart_stack.sv
// Bench for smart_stack: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized operations with occasional resets.
module tb_smart_stack;

  typedef logic [15:0] word_t;
  typedef word_t stk_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch = 1'b1;
  logic       store = 1'b0;
  logic [2:0] func = 3'b000;
  word_t      d = '0;
  word_t      dut_a, dut_b;

  int checks = 0;
  int errors = 0;

  stk_t  m_s;
  word_t m_a, m_b;

  smart_stack #(.WIDTH(16), .DEPTH(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_fetch    (fetch),
    .i_store    (store),
    .i_function (func),
    .i_write_D  (d),
    .o_read_A   (dut_a),
    .o_read_B   (dut_b)
  );

  always #5 clk = ~clk;

  // Stack operations expressed as queue manipulations, top of stack at the front.
  function automatic stk_t apply(input stk_t s, input logic [2:0] f, input word_t dv);
    word_t q[$];
    word_t t;
    stk_t  r;
    foreach (s[i]) q.push_back(s[i]);
    case (f)
      3'd1: begin q.push_front(dv); t = q.pop_back(); end
      3'd2: begin t = q.pop_front(); q.push_back('0); end
      3'd3: begin q.push_front(q[0]); t = q.pop_back(); end
      3'd4: begin t = q[0]; q[0] = q[1]; q[1] = t; end
      3'd5: begin q.push_front(q[1]); t = q.pop_back(); end
      3'd6: q[0] = dv;
      3'd7: begin t = q.pop_front(); t = q.pop_front(); q.push_front(dv); q.push_back('0); end
      default: ;
    endcase
    foreach (r[i]) r[i] = q[i];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    stk_t nxt;
    if (rst) begin
      m_s <= '{default: '0};
      m_a <= '0;
      m_b <= '0;
    end else begin
      nxt = store ? apply(m_s, func, d) : m_s;
      m_s <= nxt;
      if (fetch) begin
        m_a <= nxt[0];
        m_b <= nxt[1];
      end
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("model_a", dut_a, m_a);
        check("model_b", dut_b, m_b);
      end
    end
  end

  task automatic op(input logic f, input logic s, input logic [2:0] fn, input word_t dv);
    @(negedge clk);
    fetch = f;
    store = s;
    func  = fn;
    d     = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    store = 1'b0;
    fetch = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_ab(input string name, input word_t ea, input word_t eb);
    check({name, "_a"}, dut_a, ea);
    check({name, "_b"}, dut_b, eb);
  endtask

  initial begin
    // Reset, then idle with function undriven.
    func = 3'bxxx;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, 3'bxxx, 16'hffff);
      expect_ab("idle", 16'h0000, 16'h0000);
    end

    // Push / drop with underflow zero-fill.
    op(1'b1, 1'b1, 3'd1, 16'h0011);
    op(1'b1, 1'b1, 3'd1, 16'h0022);
    op(1'b1, 1'b1, 3'd1, 16'h0033);
    expect_ab("push3", 16'h0033, 16'h0022);
    op(1'b1, 1'b1, 3'd2, 16'h0000);
    expect_ab("drop1", 16'h0022, 16'h0011);
    op(1'b1, 1'b1, 3'd2, 16'h0000);
    op(1'b1, 1'b1, 3'd2, 16'h0000);
    expect_ab("drop3", 16'h0000, 16'h0000);

    // SWAP, OVER, DUP.
    op(1'b1, 1'b1, 3'd1, 16'h0011);
    op(1'b1, 1'b1, 3'd1, 16'h0022);
    op(1'b1, 1'b1, 3'd4, 16'h0000);
    expect_ab("swap", 16'h0011, 16'h0022);
    op(1'b1, 1'b1, 3'd5, 16'h0000);
    expect_ab("over", 16'h0022, 16'h0011);
    op(1'b1, 1'b1, 3'd3, 16'h0000);
    expect_ab("dup", 16'h0022, 16'h0022);

    // REPL2 consumes A and B; REPL1 replaces A only.
    pulse_reset();
    op(1'b1, 1'b1, 3'd1, 16'h0009);
    op(1'b1, 1'b1, 3'd1, 16'h0007);
    op(1'b1, 1'b1, 3'd1, 16'h0005);
    op(1'b1, 1'b1, 3'd7, 16'h000c);
    expect_ab("repl2", 16'h000c, 16'h0009);
    op(1'b1, 1'b1, 3'd6, 16'h0001);
    expect_ab("repl1", 16'h0001, 16'h0009);

    // Overflow: value 1 falls off the bottom.
    pulse_reset();
    for (int i = 1; i <= 9; i++) op(1'b1, 1'b1, 3'd1, word_t'(i));
    expect_ab("full", 16'h0009, 16'h0008);
    for (int i = 8; i >= 2; i--) begin
      op(1'b1, 1'b1, 3'd2, 16'h0000);
      check("drain_a", dut_a, word_t'(i));
    end
    op(1'b1, 1'b1, 3'd2, 16'h0000);
    check("lost_a", dut_a, 16'h0000);

    // Fetch gating and asynchronous reset between edges.
    pulse_reset();
    op(1'b1, 1'b1, 3'd1, 16'h0033);
    op(1'b0, 1'b1, 3'd1, 16'h00aa);
    expect_ab("nofetch", 16'h0033, 16'h0000);
    op(1'b1, 1'b1, 3'd0, 16'h0000);
    expect_ab("resync", 16'h00aa, 16'h0033);
    #2 rst = 1'b1;
    #1 expect_ab("async_rst", 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Randomized operations, mostly with fetch high, occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else op(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)), 16'($urandom));
    end

    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
